vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 VGA raster timing from the 100 MHz system clock.
- Drives pix_x/pix_y into vga_screen_pic and samples its BGR-ordered rgb output after a fixed pipeline latency that covers the ROM read.
- Drives the physical VGA pins (4-bit R/G/B, active-low hsync/vsync), so it is the consumer/driver end of the pixel-coordinate/colour interface.
- Emits a per-frame vblank tick for game-state update.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal 1..16
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- PIPE_LAT, 1, pixel ticks from coordinate presentation to rgb valid; legal 1..4

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- rgb  in  12  pixel colour from renderer, BGR packed: [11:8]=B, [7:4]=G, [3:0]=R
- pix_x  out  10  current visible column 0..639; 0 when blanking
- pix_y  out  9  current visible row 0..479; 0 when blanking
- pix_valid  out  1  high when the current coordinate is visible
- pix_ce  out  1  one-clk pixel-tick strobe
- vblank_tick  out  1  one-clk pulse at the start of vertical blank
- vga_r  out  4  red to DAC
- vga_g  out  4  green to DAC
- vga_b  out  4  blue to DAC
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n); all flops clear immediately on assertion, and release is synchronous to clk.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, pix_ce=0, vblank_tick=0
  - pix_x=0, pix_y=0, pix_valid=1 (counters at 0,0)
  - vga_r/g/b=0, hsync=1, vsync=1
  - Delay-line stages reset to active=0, hsync=1, vsync=1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_ce is registered and high for exactly one clk when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_ce constantly high after the first clk following reset.
- Counters advance only on clk edges where pix_ce=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
  - Both-wrap case: (799,524) -> (0,0) in one tick.
- Coordinates, combinational from the counters:
  - active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - pix_valid = active
  - pix_x = active ? h_cnt : 0; pix_y = active ? v_cnt[8:0] : 0
  - Coordinates are stable for CLK_DIV clks, which the renderer ROM (1-clk read) relies on.
- Raw sync:
  - hsync_raw=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync_raw=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- Alignment pipeline:
  - active, hsync_raw and vsync_raw pass through PIPE_LAT-1 delay stages, shifted only on pix_ce.
  - On the next pix_ce, the output registers load:
    - hsync/vsync from the delayed values
    - {vga_b,vga_g,vga_r} = delayed_active ? {rgb[11:8],rgb[7:4],rgb[3:0]} : 0
  - Outputs updated at tick n+PIPE_LAT correspond to the counter state held after tick n.
  - rgb is sampled only on pix_ce edges. Blanking forces black regardless of rgb.
- vblank_tick:
  - One-clk pulse, coincident with pix_ce, on the tick at which the counters become (h=0, v=V_ACTIVE).
  - Exactly one pulse per frame.
- Outputs hold between pix_ce strobes.
- Reset mid-frame: immediate return to reset values. The raster restarts at (0,0), and the first pix_ce arrives CLK_DIV clks after rst_n release.
- Width rules: h_cnt 10 bits, v_cnt 10 bits; pix_y takes the low 9 bits of v_cnt, valid because v_cnt<480 when active.

Test Plan:
- Reset, CLK_DIV=4: hold rst_n=0 for 10 clks, release. pix_ce first high at clk 4 after release, then every 4 clks. hsync=vsync=1, vga_rgb=0 until the first output update.
- Line timing, PIPE_LAT=1: count pix_ce from release.
  - hsync falls on the output update at tick 657 and rises at tick 753.
  - Line period is 800 ticks; pix_x=639 at tick 639 and 0 at tick 640.
- Frame timing: vsync low for exactly 2x800 ticks, beginning at the line-490 start plus PIPE_LAT. The frame repeats every 420000 ticks. vblank_tick fires once per frame at counter (0,480).
- Colour mapping and blanking:
  - rgb=12'hF21 while active -> next tick vga_b=F, vga_g=2, vga_r=1.
  - rgb=12'hFFF during h_cnt 640..799 -> vga outputs 0.
- Latency sweep, PIPE_LAT=3: a renderer model returns rgb=pix_x[3:0] replicated. vga_r at tick n+3 equals pix_x at tick n, and the sync edges shift by +2 ticks relative to PIPE_LAT=1.
- Mid-frame reset and CLK_DIV=1:
  - Assert rst_n at v=200 -> all outputs at reset values asynchronously, with no clk edge needed.
  - With CLK_DIV=1, pix_ce stays high and a line is 800 clks.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 raster timing, renderer alignment and VGA pin driver.
// Ports: clk, rst_n, rgb(BGR in) -> pix_x/pix_y/pix_valid/pix_ce/vblank_tick, vga_r/g/b, hsync, vsync.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic        pix_ce,
    output logic        vblank_tick,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs_raw;
    logic       vs_raw;
    logic       act_d;
    logic       hs_d;
    logic       vs_d;

    // Pixel-rate strobe; registered so it is a clean one-clk pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            if (div_cnt == DIV_MAX) div_cnt <= '0;
            else                    div_cnt <= div_cnt + 4'd1;
            pix_ce <= (div_cnt == DIV_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) v_cnt <= '0;
                else                 v_cnt <= v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign pix_valid = active;
    assign pix_x     = active ? h_cnt : '0;
    assign pix_y     = active ? v_cnt[8:0] : '0;
    assign hs_raw    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    // Pulses in the pix_ce clk whose edge moves the raster to (0, V_ACTIVE).
    assign vblank_tick = pix_ce && (h_cnt == H_LAST) && (v_cnt == V_ACT_M1);

    // Delay line matching the renderer latency; the output register is the last stage.
    generate
        if (PIPE_LAT > 1) begin : g_dly
            logic [PIPE_LAT-2:0] dly_act;
            logic [PIPE_LAT-2:0] dly_hs;
            logic [PIPE_LAT-2:0] dly_vs;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_act <= '0;
                    dly_hs  <= '1;
                    dly_vs  <= '1;
                end else if (pix_ce) begin
                    dly_act[0] <= active;
                    dly_hs[0]  <= hs_raw;
                    dly_vs[0]  <= vs_raw;
                    for (int i = 1; i < PIPE_LAT - 1; i++) begin
                        dly_act[i] <= dly_act[i-1];
                        dly_hs[i]  <= dly_hs[i-1];
                        dly_vs[i]  <= dly_vs[i-1];
                    end
                end
            end

            assign act_d = dly_act[PIPE_LAT-2];
            assign hs_d  = dly_hs[PIPE_LAT-2];
            assign vs_d  = dly_vs[PIPE_LAT-2];
        end else begin : g_nodly
            assign act_d = active;
            assign hs_d  = hs_raw;
            assign vs_d  = vs_raw;
        end
    endgenerate

    // Blanking forces black regardless of what the renderer returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_ce) begin
            hsync <= hs_d;
            vsync <= vs_d;
            vga_b <= act_d ? rgb[11:8] : 4'h0;
            vga_g <= act_d ? rgb[7:4]  : 4'h0;
            vga_r <= act_d ? rgb[3:0]  : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for vga_timing_ctrl.
// Two instances: full 640x480 timing (div 4, lat 1) and a small raster (div 1, lat 3).
module tb_vga_timing_ctrl;

    localparam int S_HS  = 0;
    localparam int S_VS  = 1;
    localparam int S_X   = 2;
    localparam int S_Y   = 3;
    localparam int S_VAL = 4;
    localparam int S_RGB = 5;
    localparam int S_VB  = 6;
    localparam int S_CE  = 7;

    typedef struct {
        int    tick;
        int    sel;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [11:0] rgb_a, rgb_b;
    logic [9:0]  pix_x_a, pix_x_b;
    logic [8:0]  pix_y_a, pix_y_b;
    logic        pix_valid_a, pix_valid_b;
    logic        pix_ce_a, pix_ce_b;
    logic        vb_a, vb_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, hs_b, vs_b;

    int n_checks = 0;
    int n_errors = 0;
    int tick_a = 0;
    int tick_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_ctrl #(.CLK_DIV(4), .PIPE_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .rgb(rgb_a),
        .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_valid(pix_valid_a),
        .pix_ce(pix_ce_a), .vblank_tick(vb_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .PIPE_LAT(3),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .rgb(rgb_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_valid(pix_valid_b),
        .pix_ce(pix_ce_b), .vblank_tick(vb_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .hsync(hs_b), .vsync(vs_b)
    );

    // Renderer A: solid F21 when visible, white when blank (must be masked).
    assign rgb_a = pix_valid_a ? 12'hF21 : 12'hFFF;

    // Renderer B: two-tick latency returning pix_x[3:0] on all channels.
    logic [9:0] rd1, rd2;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (pix_ce_b) begin
            rd1 <= pix_x_b;
            rd2 <= rd1;
        end
    end
    assign rgb_b = {rd2[3:0], rd2[3:0], rd2[3:0]};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic push_a(int t, int sel, int val, string nm);
        exp_t e;
        e.tick = t; e.sel = sel; e.val = val; e.name = nm;
        qa.push_back(e);
    endtask

    task automatic push_b(int t, int sel, int val, string nm);
        exp_t e;
        e.tick = t; e.sel = sel; e.val = val; e.name = nm;
        qb.push_back(e);
    endtask

    function automatic logic [31:0] obs_a(int sel);
        case (sel)
            S_HS:    return 32'(hs_a);
            S_VS:    return 32'(vs_a);
            S_X:     return 32'(pix_x_a);
            S_Y:     return 32'(pix_y_a);
            S_VAL:   return 32'(pix_valid_a);
            S_RGB:   return 32'({b_a, g_a, r_a});
            S_VB:    return 32'(vb_a);
            default: return 32'(pix_ce_a);
        endcase
    endfunction

    function automatic logic [31:0] obs_b(int sel);
        case (sel)
            S_HS:    return 32'(hs_b);
            S_VS:    return 32'(vs_b);
            S_X:     return 32'(pix_x_b);
            S_Y:     return 32'(pix_y_b);
            S_VAL:   return 32'(pix_valid_b);
            S_RGB:   return 32'({b_b, g_b, r_b});
            S_VB:    return 32'(vb_b);
            default: return 32'(pix_ce_b);
        endcase
    endfunction

    // Monitors: tick = number of pix_ce edges since reset release.
    always @(negedge clk) begin
        if (!rst_a) begin
            tick_a = 0;
        end else begin
            while (qa.size() > 0 && qa[0].tick <= tick_a) begin
                exp_t e;
                e = qa.pop_front();
                if (e.tick != tick_a) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s: missed at tick %0d", e.name, e.tick);
                end else begin
                    chk($sformatf("%s@%0d", e.name, e.tick), obs_a(e.sel), 32'(e.val));
                end
            end
            if (pix_ce_a) tick_a++;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            tick_b = 0;
        end else begin
            while (qb.size() > 0 && qb[0].tick <= tick_b) begin
                exp_t e;
                e = qb.pop_front();
                if (e.tick != tick_b) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s: missed at tick %0d", e.name, e.tick);
                end else begin
                    chk($sformatf("%s@%0d", e.name, e.tick), obs_b(e.sel), 32'(e.val));
                end
            end
            if (pix_ce_b) tick_b++;
        end
    end

    task automatic ce_start_a(string nm);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_ce_clk%0d", nm, k), 32'(pix_ce_a), 32'((k % 4) == 0));
        end
    endtask

    initial begin
        int budget;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_pix_ce", 32'(pix_ce_a), 0);
        chk("rst_pix_valid", 32'(pix_valid_a), 1);
        chk("rst_hsync", 32'(hs_a), 1);
        chk("rst_vsync", 32'(vs_a), 1);

        push_a(0, S_HS, 1, "a_hs");
        push_a(0, S_VS, 1, "a_vs");
        push_a(0, S_RGB, 0, "a_rgb");
        push_a(0, S_X, 0, "a_x");
        push_a(0, S_Y, 0, "a_y");
        push_a(0, S_VAL, 1, "a_val");
        push_a(1, S_RGB, 'hF21, "a_rgb");
        push_a(500, S_VS, 1, "a_vs");
        push_a(639, S_X, 639, "a_x");
        push_a(639, S_VAL, 1, "a_val");
        push_a(640, S_X, 0, "a_x");
        push_a(640, S_VAL, 0, "a_val");
        push_a(640, S_RGB, 'hF21, "a_rgb");
        push_a(641, S_RGB, 0, "a_rgb_blank");
        push_a(656, S_HS, 1, "a_hs");
        push_a(657, S_HS, 0, "a_hs_fall");
        push_a(752, S_HS, 0, "a_hs");
        push_a(753, S_HS, 1, "a_hs_rise");
        push_a(799, S_Y, 0, "a_y_blank");
        push_a(800, S_Y, 1, "a_y");
        push_a(800, S_RGB, 0, "a_rgb_blank");
        push_a(801, S_RGB, 'hF21, "a_rgb");
        push_a(1456, S_HS, 1, "a_hs");
        push_a(1457, S_HS, 0, "a_hs_line2");
        push_a(1660, S_X, 60, "a_x");
        push_a(1660, S_Y, 2, "a_y");

        push_b(0, S_HS, 1, "b_hs");
        push_b(0, S_RGB, 0, "b_rgb");
        push_b(5, S_X, 5, "b_x");
        push_b(8, S_RGB, 'h555, "b_rgb_lat");
        push_b(16, S_VAL, 0, "b_val");
        push_b(18, S_RGB, 'hFFF, "b_rgb_lat");
        push_b(19, S_RGB, 0, "b_rgb_blank");
        push_b(20, S_HS, 1, "b_hs");
        push_b(21, S_HS, 0, "b_hs_fall");
        push_b(23, S_HS, 0, "b_hs");
        push_b(24, S_HS, 1, "b_hs_rise");
        push_b(30, S_RGB, 'h333, "b_rgb_lat");
        push_b(44, S_HS, 1, "b_hs");
        push_b(45, S_HS, 0, "b_hs_line2");
        push_b(100, S_CE, 1, "b_ce");
        push_b(142, S_VB, 0, "b_vb");
        push_b(143, S_VB, 1, "b_vb_pulse");
        push_b(144, S_VB, 0, "b_vb");
        push_b(170, S_VS, 1, "b_vs");
        push_b(171, S_VS, 0, "b_vs_fall");
        push_b(218, S_VS, 0, "b_vs");
        push_b(219, S_VS, 1, "b_vs_rise");
        push_b(383, S_VB, 1, "b_vb_frame2");
        push_b(410, S_VS, 1, "b_vs");
        push_b(411, S_VS, 0, "b_vs_frame2");

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        ce_start_a("a_start");

        budget = 0;
        while (tick_a < 1662 && budget < 8000) begin
            @(posedge clk);
            budget++;
        end
        chk("a_wait_1662", 32'(tick_a >= 1662), 1);

        // Mid-frame reset, checked before any further clk edge.
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        chk("mrst_x", 32'(pix_x_a), 0);
        chk("mrst_y", 32'(pix_y_a), 0);
        chk("mrst_val", 32'(pix_valid_a), 1);
        chk("mrst_rgb", 32'({b_a, g_a, r_a}), 0);
        chk("mrst_hs", 32'(hs_a), 1);
        chk("mrst_vs", 32'(vs_a), 1);
        chk("mrst_ce", 32'(pix_ce_a), 0);
        chk("mrst_vb", 32'(vb_a), 0);

        push_a(0, S_X, 0, "a2_x");
        push_a(0, S_RGB, 0, "a2_rgb");
        push_a(1, S_RGB, 'hF21, "a2_rgb");
        push_a(5, S_X, 5, "a2_x");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        ce_start_a("a_restart");

        budget = 0;
        while ((qa.size() > 0 || qb.size() > 0) && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        chk("queues_drained", 32'(qa.size() + qb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
